// File: rtl/decade_scan_ctrl.sv
// BCD decade counter chain with IDLE/RUN/PAUSE sequencing and a multiplexed seven-segment scan.
// Define DECADE_SCAN_LZB_EN to enable leading-zero blanking on the segment bus.
module decade_scan_ctrl #(
    parameter int unsigned TICK_DIV   = 100000000,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_start,
    input  logic                    cmd_stop,
    input  logic                    cmd_clear,
    output logic                    running,
    output logic                    wrap,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [6:0]              seg
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [TW-1:0] TickLast = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] ScanLast = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IdxLast  = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    state_e                       state_q, state_d;
    logic [TW-1:0]                presc_q, presc_d;
    logic [NUM_DIGITS-1:0][3:0]   digits_q, digits_d;
    logic                         running_q, wrap_q, wrap_d;
    logic [SW-1:0]                scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]                scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0]        digit_sel_q, digit_sel_d;
    logic [6:0]                   seg_q, seg_d;
    logic                         tick, tick_eff, carry;
    logic [3:0]                   sel_digit;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h01;
            4'd1:    glyph = 7'h4F;
            4'd2:    glyph = 7'h12;
            4'd3:    glyph = 7'h06;
            4'd4:    glyph = 7'h4C;
            4'd5:    glyph = 7'h24;
            4'd6:    glyph = 7'h20;
            4'd7:    glyph = 7'h0F;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h04;
            default: glyph = 7'h7F;
        endcase
    endfunction

    // Priority clear > stop > start; an asserted stop masks start in the same cycle.
    always_comb begin
        state_d = state_q;
        if (cmd_clear) begin
            state_d = StIdle;
        end else if (cmd_stop) begin
            if (state_q == StRun) state_d = StPause;
        end else if (cmd_start) begin
            if (state_q != StRun) state_d = StRun;
        end
    end

    assign tick     = (state_q == StRun) && (presc_q == TickLast);
    assign tick_eff = tick && !cmd_clear && !cmd_stop;

    always_comb begin
        presc_d = '0;
        if (state_q == StRun && state_d == StRun && !tick) presc_d = presc_q + 1'b1;
    end

    // Ripple the carry through every digit within the tick cycle.
    always_comb begin
        digits_d = digits_q;
        wrap_d   = 1'b0;
        carry    = 1'b0;
        if (cmd_clear) begin
            digits_d = '0;
        end else if (tick_eff) begin
            carry = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (carry) begin
                    if (digits_q[i] == 4'd9) begin
                        digits_d[i] = 4'd0;
                    end else begin
                        digits_d[i] = digits_q[i] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
            wrap_d = carry;
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == ScanLast) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IdxLast) ? '0 : scan_idx_q + 1'b1;
        end
    end

    // Segments are built from next-state values so seg tracks count_bcd on the same edge.
    always_comb begin
        digit_sel_d             = '0;
        digit_sel_d[scan_idx_d] = 1'b1;
        sel_digit               = digits_d[scan_idx_d];
        seg_d                   = glyph(sel_digit);
`ifdef DECADE_SCAN_LZB_EN
        if (scan_idx_d != '0) begin
            seg_d = 7'h7F;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (i >= int'(scan_idx_d) && digits_d[i] != 4'd0) seg_d = glyph(sel_digit);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            presc_q     <= '0;
            digits_q    <= '0;
            running_q   <= 1'b0;
            wrap_q      <= 1'b0;
            scan_cnt_q  <= '0;
            scan_idx_q  <= '0;
            digit_sel_q <= NUM_DIGITS'(1);
            seg_q       <= 7'h01;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            digits_q    <= digits_d;
            running_q   <= (state_d == StRun);
            wrap_q      <= wrap_d;
            scan_cnt_q  <= scan_cnt_d;
            scan_idx_q  <= scan_idx_d;
            digit_sel_q <= digit_sel_d;
            seg_q       <= seg_d;
        end
    end

    assign running   = running_q;
    assign wrap      = wrap_q;
    assign count_bcd = digits_q;
    assign digit_sel = digit_sel_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_decade_scan_ctrl.sv
// Self-checking bench for decade_scan_ctrl against an integer-valued reference model.
module tb_decade_scan_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int SCAN_DIV   = 2;
    localparam int NUM_DIGITS = 4;
    localparam int MODULUS    = 10000;
`ifdef DECADE_SCAN_LZB_EN
    localparam bit Lzb = 1'b1;
`else
    localparam bit Lzb = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, cmd_start, cmd_stop, cmd_clear;
    logic        running, wrap;
    logic [15:0] count_bcd;
    logic [3:0]  digit_sel;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;

    // Model: state 0=idle 1=run 2=pause, count as plain integer, cycles since events.
    int m_state, m_count, m_run_cyc, m_cyc;
    bit m_wrap;

    decade_scan_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .SCAN_DIV  (SCAN_DIV),
        .NUM_DIGITS(NUM_DIGITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_start(cmd_start),
        .cmd_stop (cmd_stop),
        .cmd_clear(cmd_clear),
        .running  (running),
        .wrap     (wrap),
        .count_bcd(count_bcd),
        .digit_sel(digit_sel),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] exp_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < NUM_DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [6:0] glyph(input int d);
        logic [6:0] tbl [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
        return tbl[d];
    endfunction

    function automatic int exp_idx();
        return (m_cyc / SCAN_DIV) % NUM_DIGITS;
    endfunction

    function automatic logic [6:0] exp_seg();
        int idx = exp_idx();
        int p   = pow10(idx);
        if (Lzb && idx > 0 && m_count < p) return 7'h7F;
        return glyph((m_count / p) % 10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] sel;
        sel = 4'(1 << exp_idx());
        chk("count_bcd", count_bcd, exp_bcd(m_count));
        chk("running", running, (m_state == 1));
        chk("wrap", wrap, m_wrap);
        chk("digit_sel", digit_sel, sel);
        chk("seg", seg, exp_seg());
    endtask

    task automatic model_step(input bit s, input bit p, input bit c);
        bit tk;
        int nxt;
        tk  = (m_state == 1) && (m_run_cyc % TICK_DIV == TICK_DIV - 1);
        nxt = m_state;
        if (c) nxt = 0;
        else if (p) begin if (m_state == 1) nxt = 2; end
        else if (s) begin if (m_state != 1) nxt = 1; end
        m_wrap = 1'b0;
        if (c) m_count = 0;
        else if (tk && !p) begin
            if (m_count == MODULUS - 1) begin
                m_count = 0;
                m_wrap  = 1'b1;
            end else begin
                m_count++;
            end
        end
        m_run_cyc = (nxt == 1 && m_state == 1) ? m_run_cyc + 1 : 0;
        m_state   = nxt;
        m_cyc++;
    endtask

    task automatic step(input bit s, input bit p, input bit c);
        rst = 1'b0; cmd_start = s; cmd_stop = p; cmd_clear = c;
        @(posedge clk);
        model_step(s, p, c);
        #1;
        check_all();
    endtask

    task automatic do_reset(input bit s, input bit p, input bit c);
        rst = 1'b1; cmd_start = s; cmd_stop = p; cmd_clear = c;
        @(posedge clk);
        m_state = 0; m_count = 0; m_run_cyc = 0; m_cyc = 0; m_wrap = 1'b0;
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_until(input int target, input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            if (m_count == target) break;
            step(1'b0, 1'b0, 1'b0);
        end
        chk(tag, count_bcd, exp_bcd(target));
    endtask

    initial begin
        logic [6:0] e;
        int r;
        rst = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_clear = 1'b0;

        // Reset while commands are asserted; they must be ignored.
        do_reset(1'b1, 1'b1, 1'b1);
        chk("rst_count", count_bcd, 16'h0000);
        chk("rst_sel", digit_sel, 4'b0001);
        chk("rst_seg", seg, 7'h01);
        idle(20);
        chk("idle_count", count_bcd, 16'h0000);

        // First tick lands TICK_DIV cycles after entering RUN.
        step(1'b1, 1'b0, 1'b0);
        chk("run_entry", running, 1'b1);
        idle(3);
        chk("pre_first_tick", count_bcd, 16'h0000);
        idle(1);
        chk("first_tick", count_bcd, 16'h0001);
        idle(36);
        chk("ten_ticks", count_bcd, 16'h0010);

        // Stop in the tick cycle: tick discarded, value frozen, resumes with a full period.
        idle(36);
        chk("at_19", count_bcd, 16'h0019);
        idle(3);
        step(1'b0, 1'b1, 1'b0);
        chk("stop_drops_tick", count_bcd, 16'h0019);
        chk("paused", running, 1'b0);
        idle(20);
        chk("pause_hold", count_bcd, 16'h0019);
        step(1'b1, 1'b0, 1'b0);
        idle(3);
        chk("resume_pending", count_bcd, 16'h0019);
        idle(1);
        chk("resume_tick", count_bcd, 16'h0020);

        // Full rollover from 9999.
        run_until(9999, 45000, "reach_9999");
        for (int i = 0; i < 8; i++) begin
            if (m_wrap) break;
            step(1'b0, 1'b0, 1'b0);
        end
        chk("wrap_pulse", wrap, 1'b1);
        chk("wrap_zero", count_bcd, 16'h0000);
        step(1'b0, 1'b0, 1'b0);
        chk("wrap_one_cycle", wrap, 1'b0);

        // All commands at once in RUN: clear wins.
        run_until(123, 1000, "reach_0123");
        step(1'b1, 1'b1, 1'b1);
        chk("combo_count", count_bcd, 16'h0000);
        chk("combo_running", running, 1'b0);
        idle(8);

        // Display of 0042, paused so the value stays put.
        step(1'b1, 1'b0, 1'b0);
        run_until(42, 400, "reach_0042");
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 1'b0);
            case (digit_sel)
                4'b1000, 4'b0100: e = Lzb ? 7'h7F : 7'h01;
                4'b0010:          e = 7'h4C;
                default:          e = 7'h12;
            endcase
            chk("seg_0042", seg, e);
        end

        // Reset in the middle of a count with start held.
        step(1'b1, 1'b0, 1'b0);
        idle(10);
        do_reset(1'b1, 1'b0, 1'b0);
        chk("midrun_rst", count_bcd, 16'h0000);

        // Random command traffic, one command per cycle, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 6)       step(1'b1, 1'b0, 1'b0);
            else if (r < 8)  step(1'b0, 1'b1, 1'b0);
            else if (r < 9)  step(1'b0, 1'b0, 1'b1);
            else if (r == 99) do_reset(r[0], r[1], r[2]);
            else             step(1'b0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decade_scan_ctrl.md
Name: decade_scan_ctrl

Overview:
- Controller for a chain of NUM_DIGITS decade (BCD 0-9) counters driving one multiplexed common-anode seven-segment display.
- Generates the count tick from a prescaler and sequences counting through an IDLE/RUN/PAUSE state machine.
- Time-multiplexes the digit values onto a single segment bus with a one-hot digit select.
- Sits between board push-button/command logic and the display pins; it replaces per-digit free-running counters.

Parameters:
- TICK_DIV, 100000000, clk cycles per count tick (minimum 2).
- SCAN_DIV, 50000, clk cycles each digit stays selected (minimum 1).
- NUM_DIGITS, 4, number of cascaded decade digits (1-8).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- cmd_start  input  1  start or resume counting.
- cmd_stop  input  1  pause counting.
- cmd_clear  input  1  zero all digits and return to IDLE.
- running  output  1  high while in RUN.
- wrap  output  1  one-cycle pulse when the count rolls over from all 9s to all 0s.
- count_bcd  output  4*NUM_DIGITS  packed BCD value; digit 0 (least significant) in [3:0].
- digit_sel  output  NUM_DIGITS  one-hot enable for the active digit; high = enabled.
- seg  output  7  segments a..g, seg[6]=a, seg[0]=g; active-low.

Behaviour:
- Single clock domain: clk. rst is synchronous and active-high.
- Reset values: state=IDLE, running=0, wrap=0, count_bcd=0, prescaler=0, scan counter=0, scan index=0, digit_sel=1 (digit 0), seg=7'h01 (glyph "0").
- States and transitions:
  - IDLE: on cmd_start, go to RUN.
  - RUN: on cmd_stop, go to PAUSE.
  - PAUSE: on cmd_start, go to RUN; digits are held across the pause.
  - Any state: cmd_clear goes to IDLE and zeroes all digits.
- Command priority within one cycle: clear > stop > start. Commands are sampled every cycle, so holding a level is harmless. cmd_start in RUN and cmd_stop in IDLE or PAUSE have no effect.
- running is registered and equals (state==RUN).
- Prescaler:
  - Increments only in RUN. It is forced to 0 in IDLE and PAUSE and on any state change.
  - When the prescaler equals TICK_DIV-1 it returns to 0 and a tick occurs.
  - The first tick therefore comes TICK_DIV cycles after entering RUN.
- On a tick:
  - Digit 0 increments.
  - A digit at 9 rolls to 0 and carries into the next digit. The whole carry chain resolves in the same cycle.
  - count_bcd updates on the clock edge following the tick cycle.
- Rollover from all 9s: every digit goes to 0 and wrap=1 for exactly that one cycle. Counting continues.
- Tick in the same cycle as cmd_clear or cmd_stop: the tick is discarded; the command takes effect.
- Digits never hold values 10-15.
- Scan:
  - Runs in every state.
  - The scan counter advances every cycle; at SCAN_DIV-1 it returns to 0 and the scan index advances, wrapping from NUM_DIGITS-1 to 0.
  - digit_sel and seg are both registered from the scan index and the digit values, so they change on the same edge.
  - seg reflects a digit change no later than 1 cycle after count_bcd changes while that digit is selected.
  - Exactly one digit_sel bit is high at all times.
- Segment codes (hex, a=MSB): 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F, 8=00, 9=04. Blank = 7F.
- rst in the middle of a count or scan: everything returns to its reset values on the next edge, regardless of any command input.

Optional Feature:
- Macro: DECADE_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - While a digit is selected, seg=7F if that digit and every more-significant digit are 0.
  - Digit 0 is never blanked. Example: 0042 shows blank, blank, 4, 2.
  - digit_sel is unaffected.
- Undefined: all digits always show their glyph; no blanking logic is synthesised.

Test Plan (TICK_DIV=4, SCAN_DIV=2, NUM_DIGITS=4):
- Reset, then idle 20 cycles -> count_bcd=0000, running=0, digit_sel cycles 1,2,4,8 every 2 cycles, seg=01 throughout.
- Pulse cmd_start, run 40 cycles -> 10 ticks, count_bcd=0010, first increment 4 cycles after RUN entry.
- From 0019, pulse cmd_stop just before a tick, wait 20 cycles, pulse cmd_start -> value frozen at 0019 during PAUSE; becomes 0020 exactly 4 cycles after resume.
- Preload to 9999 via ticks, allow one more tick -> count_bcd=0000 and wrap high for exactly 1 cycle.
- Assert cmd_clear, cmd_stop and cmd_start together while RUN at 0123 -> next cycle count_bcd=0000, state IDLE, running=0.
- With DECADE_SCAN_LZB_EN defined, count 0042 -> seg=7F on digits 3 and 2, 4C on digit 1, 12 on digit 0. With the macro undefined, digits 3 and 2 show 01.
